// File: rtl/chan_mux_pkg.sv
// rtl/chan_mux_pkg.sv - shared mode encodings and width helper for chan_mux_arb
package chan_mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotate-priority arbiter: first request after ptr wins
module rr_arbiter
   import chan_mux_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_vld,
   output logic [SELW-1:0] gnt_idx
);

   // Scan from farthest to nearest so the channel right after ptr overwrites the rest.
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NCH;
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/chan_mux_arb.sv
// rtl/chan_mux_arb.sv - N:1 valid/ready channel mux, explicit select or round-robin
// Define CHAN_MUX_ARB_SKID_EN for a 2-entry skid FIFO output stage.
module chan_mux_arb
   import chan_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*WIDTH-1:0]   in_data,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic                   mode,
   input  logic [clog2(NCH)-1:0]  sel,
   output logic [WIDTH-1:0]       out_data,
   output logic [clog2(NCH)-1:0]  out_chan,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int SELW = clog2(NCH);

   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
   logic             rr_vld;
   logic [SELW-1:0]  rr_idx;
   logic             gnt_vld;
   logic [SELW-1:0]  gnt_idx;
   logic             space;
   logic             push;
   logic [WIDTH-1:0] push_data;

   rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .gnt_vld (rr_vld),
      .gnt_idx (rr_idx)
   );

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = sel;
      if (mode == MODE_RR) begin
         gnt_vld = rr_vld;
         gnt_idx = rr_idx;
      end else if (int'(sel) < NCH) begin
         gnt_vld = in_valid[sel];
      end
   end

   assign push      = gnt_vld & space;
   assign push_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

   always_comb begin
      in_ready = '0;
      if (gnt_vld && space) in_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push && mode == MODE_RR) rr_ptr_d = gnt_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= SELW'(NCH - 1);
      else        rr_ptr_q <= rr_ptr_d;
   end

`ifdef CHAN_MUX_ARB_SKID_EN
   logic [WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [SELW-1:0]  head_chan_q, head_chan_d, tail_chan_q, tail_chan_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             pop;

   assign space = (cnt_q < 2'd2);
   assign pop   = (cnt_q != 2'd0) & out_ready;

   // Push with pop implies count is 1, so the new word goes straight to the head.
   always_comb begin
      head_data_d = head_data_q;
      head_chan_d = head_chan_q;
      tail_data_d = tail_data_q;
      tail_chan_d = tail_chan_q;
      cnt_d       = cnt_q;
      if (push && pop) begin
         head_data_d = push_data;
         head_chan_d = gnt_idx;
      end else if (push) begin
         if (cnt_q == 2'd0) begin
            head_data_d = push_data;
            head_chan_d = gnt_idx;
         end else begin
            tail_data_d = push_data;
            tail_chan_d = gnt_idx;
         end
         cnt_d = cnt_q + 2'd1;
      end else if (pop) begin
         head_data_d = tail_data_q;
         head_chan_d = tail_chan_q;
         cnt_d       = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_data_q <= '0;
         head_chan_q <= '0;
         tail_data_q <= '0;
         tail_chan_q <= '0;
         cnt_q       <= '0;
      end else begin
         head_data_q <= head_data_d;
         head_chan_q <= head_chan_d;
         tail_data_q <= tail_data_d;
         tail_chan_q <= tail_chan_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_data  = head_data_q;
   assign out_chan  = head_chan_q;
   assign out_valid = (cnt_q != 2'd0);
`else
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;

   assign space = ~out_valid_q | out_ready;

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q & ~out_ready;
      if (push) begin
         out_data_d  = push_data;
         out_chan_d  = gnt_idx;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_chan_mux_arb.sv
// tb/tb_chan_mux_arb.sv - directed vector bench for chan_mux_arb
module tb_chan_mux_arb;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic         mode;
   logic [1:0]   sel;
   logic [31:0]  out_data;
   logic [1:0]   out_chan;
   logic         out_valid;
   logic         out_ready;

   int passed = 0;
   int total  = 0;

   chan_mux_arb #(.WIDTH(32), .NCH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] vld;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [1:0] exp_ch;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [31:0] word(input logic [1:0] ch);
      return 32'hA5A5_0000 | {30'd0, ch};
   endfunction

   initial begin
      tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[1]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2};
      tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[10] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[11] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
      tbl[12] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[13] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[14] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};

      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = word(2'(i));
      rst_n = 1'b0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_data", out_data, 32'd0);
      chk("reset out_chan", {30'd0, out_chan}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset in_ready idle", {28'd0, in_ready}, 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d in_ready", i), {28'd0, in_ready}, {28'd0, tbl[i].exp_rdy});
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
         chk($sformatf("vec%0d out_chan", i), {30'd0, out_chan}, {30'd0, tbl[i].exp_ch});
         chk($sformatf("vec%0d out_data", i), out_data, word(tbl[i].exp_ch));
      end

      // Backpressure: word from channel 3 is held while downstream stalls.
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
`ifdef CHAN_MUX_ARB_SKID_EN
         chk($sformatf("bp%0d in_ready", c), {28'd0, in_ready}, (c == 0) ? 32'd1 : 32'd0);
`else
         chk($sformatf("bp%0d in_ready", c), {28'd0, in_ready}, 32'd0);
`endif
         @(posedge clk); #1;
         chk($sformatf("bp%0d out_valid", c), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d out_chan", c), {30'd0, out_chan}, 32'd3);
         chk($sformatf("bp%0d out_data", c), out_data, word(2'd3));
      end
      in_valid = 4'b0000; out_ready = 1'b1;
      @(posedge clk); #1;
`ifdef CHAN_MUX_ARB_SKID_EN
      chk("bp drain out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp drain out_chan", {30'd0, out_chan}, 32'd0);
      @(posedge clk); #1;
`endif
      chk("bp empty out_valid", {31'd0, out_valid}, 32'd0);

      // Selected channel idle: nothing is granted even though others request.
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("selidle%0d in_ready", c), {28'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
         chk($sformatf("selidle%0d out_valid", c), {31'd0, out_valid}, 32'd0);
      end

      // Reset while a word is held.
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("prerst out_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("async rst out_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      chk("post rst in_ready", {28'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("post rst out_valid", {31'd0, out_valid}, 32'd1);
      chk("post rst out_chan", {30'd0, out_chan}, 32'd0);
      @(posedge clk); #1;
      chk("post rst second chan", {30'd0, out_chan}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
